// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data memory access per captured
// load/store, stalls upstream while it waits, and times out after a bound.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [75:0] In,
    output logic [36:0] Out,
    output logic        Stall,
    output logic [31:0] MemAddr,
    output logic [15:0] MemWData,
    output logic        MemRd,
    output logic        MemWr,
    input  logic        MemReady,
    input  logic [15:0] MemRData,
    output logic        MemTimeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   alu_q;
    logic [2:0]    rdst_q;
    logic          wb_q;
    logic          ldd_q;
    logic          wr_q;

    logic [1:0] op_in;
    logic       mem_in;
    logic       expire;

    assign op_in  = In[5:4];
    assign mem_in = (op_in == 2'b01) || (op_in == 2'b10);
    assign expire = !MemReady && (cnt == LAST);

    wire unused_ok = &{1'b0, In[11:9]};

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Enable && mem_in) state_nx = ACCESS;
            ACCESS:  if (MemReady || expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            Out        <= '0;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            alu_q      <= '0;
            rdst_q     <= '0;
            wb_q       <= 1'b0;
            ldd_q      <= 1'b0;
            wr_q       <= 1'b0;
            MemTimeout <= 1'b0;
        end else if (state == IDLE) begin
            if (Enable && mem_in) begin
                // Memory ops retire later; emit a bubble now.
                Out[1:0] <= 2'b00;
                cnt      <= '0;
                addr_q   <= (In[3:2] != 2'b00) ? In[75:44]
                                               : {16'h0, In[27:12]};
                wdata_q  <= In[43:28];
                alu_q    <= In[27:12];
                rdst_q   <= In[8:6];
                wb_q     <= In[1];
                ldd_q    <= In[0];
                wr_q     <= (op_in == 2'b10);
            end else if (Enable) begin
                Out <= {16'h0, In[27:12], In[8:6], In[1], In[0]};
            end
        end else begin
            if (MemReady) begin
                Out <= {wr_q ? 16'h0 : MemRData, alu_q, rdst_q,
                        wb_q, ldd_q};
            end else if (expire) begin
                Out        <= {16'h0, alu_q, rdst_q, 2'b00};
                MemTimeout <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign Stall    = (state == ACCESS);
    assign MemRd    = Stall && !wr_q;
    assign MemWr    = Stall && wr_q;
    assign MemAddr  = Stall ? addr_q : 32'h0;
    assign MemWData = Stall ? wdata_q : 16'h0;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of cycles in ACCESS without MemReady before the request is abandoned.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Enable  input  1  stage enable; 0 blocks capture of a new In.
REQ-005 In  input  76  EX/MEM bundle: [75:44] SP, [43:28] Rsrc value, [27:12] ALU result, [11:9] Rsrc addr, [8:6] Rdst addr, [5:4] mem op, [3:2] SP op, [1] writeback, [0] LDD.
REQ-006 Out  output  37  MEM/WB bundle: [36:21] memory read data, [20:5] ALU result, [4:2] Rdst addr, [1] writeback, [0] LDD.
REQ-007 Stall  output  1  1 = upstream holds In; this stage ignores In.
REQ-008 MemAddr  output  32  data memory address.
REQ-009 MemWData  output  16  data memory write data.
REQ-010 MemRd  output  1  read request.
REQ-011 MemWr  output  1  write request.
REQ-012 MemReady  input  1  memory completion, sampled on the rising edge.
REQ-013 MemRData  input  16  read data, valid in the cycle MemReady=1.
REQ-014 MemTimeout  output  1  sticky timeout error flag.

Function
REQ-015 Mem op decode: 01 = read, 10 = write, 00 and 11 = no access.
REQ-016 State machine states: IDLE, ACCESS.
REQ-017 In IDLE with Enable=1, In is captured on every edge; with Enable=0, no capture and Out holds.
REQ-018 Captured no-access instruction: Out is loaded on the capture edge (latency 1): data field 0, ALU result, Rdst, writeback and LDD copied; state stays IDLE.
REQ-019 Captured read or write: IDLE->ACCESS on the capture edge; Out[1] and Out[0] are cleared (bubble) on that edge.
REQ-020 In ACCESS: MemRd or MemWr = 1 per the captured op, never both; MemAddr and MemWData held constant.
REQ-021 Address: captured SP op != 00 -> MemAddr = captured SP; otherwise MemAddr = {16'h0, captured ALU result}.
REQ-022 MemWData = captured Rsrc value in ACCESS; 0 in IDLE.
REQ-023 Stall = 1 exactly while state = ACCESS (combinational from state).
REQ-024 Edge in ACCESS with MemReady=1: ACCESS->IDLE; Out loaded with data = MemRData for a read (0 for a write), plus captured ALU result, Rdst, writeback and LDD; MemRd/MemWr drop in the next cycle; minimum access latency 2 edges.
REQ-025 Wait counter: cleared on entry to ACCESS, incremented each ACCESS edge with MemReady=0.
REQ-026 When the counter reaches TIMEOUT_CYCLES with MemReady=0: ACCESS->IDLE, request dropped, Out loaded with writeback=0 and LDD=0, MemTimeout set to 1.
REQ-027 MemReady on the same edge as the timeout threshold: completion wins; no timeout.
REQ-028 MemTimeout stays 1 until Reset.
REQ-029 Enable has no effect in ACCESS; an in-flight access always runs to completion or timeout.
REQ-030 MemReady in IDLE is ignored.
REQ-031 After completion in IDLE with Enable=1, the next In is captured on the following edge; back-to-back accesses are separated by at least one IDLE cycle.
REQ-032 Counter width is sufficient for TIMEOUT_CYCLES without wrap.

Reset
REQ-033 Reset=1 on an edge forces IDLE, counter 0, Out 0, Stall 0, MemRd 0, MemWr 0, MemAddr 0, MemWData 0, MemTimeout 0.
REQ-034 Reset during ACCESS abandons the request with no Out update other than clear; Reset has priority over every other event.

Verification
REQ-035 ALU op, ALU result 16'h1234, Rdst 3'd5, writeback 1, mem op 00, Enable 1 -> next edge Out = {16'h0, 16'h1234, 3'd5, 1, 0}, Stall 0.
REQ-036 Read, SP op 01, SP 32'h000F_FFFE, LDD 1, MemReady asserted after 3 cycles with MemRData 16'hBEEF -> MemAddr 32'h000F_FFFE, MemRd 1 and Stall 1 for 3 cycles, then Out[36:21] = 16'hBEEF, Out[0] = 1, Stall 0.
REQ-037 Write, SP op 00, ALU result 16'h0040, Rsrc value 16'hA5A5, MemReady on first ACCESS edge -> MemAddr 32'h0000_0040, MemWData 16'hA5A5, MemWr 1 for one cycle, latency 2.
REQ-038 Read with MemReady held 0, TIMEOUT_CYCLES = 4 -> after 4 ACCESS edges state IDLE, Out[1] = 0, MemTimeout 1 and held until Reset.
REQ-039 Reset asserted in the second ACCESS cycle of a read -> next edge all outputs 0, state IDLE, a later MemReady pulse is ignored.
REQ-040 Enable = 0 with a read on In in IDLE -> no capture, MemRd 0, Out unchanged; Enable = 1 -> capture on the next edge.
